// File: rtl/asl_result_tx.sv
// Sign-result transmitter: filters argmax results for stability and confidence,
// maps the winning class to an ASCII character and sends it as a UART 8N1 frame.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line high, waiting for a character in the hold register
// S_START | start bit (tx low) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (tx high) for CLKS_PER_BIT cycles
module asl_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STABLE_COUNT = 4,
    parameter logic [7:0]  CONF_THRESH  = 8'd64
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data_in,
    input  logic [4:0] idx_in,
    input  logic       valid_i,
    output logic       tx,
    output logic       busy_o,
    output logic       ovf_o
);

    localparam int unsigned    BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     STABLE    = 4'(STABLE_COUNT);
    localparam logic [4:0]     IDX_NONE  = 5'd27;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    tx_state_t     state_q, state_d;
    logic [4:0]    last_idx_q, last_idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_char_q, pend_char_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          ovf_q, ovf_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          qual;
    logic [7:0]    chr;
    logic          take;

    // Classify the incoming result and map its index to a character.
    always_comb begin
        chr  = 8'h20;
        qual = (data_in >= CONF_THRESH) && ((idx_in <= 5'd26) || (idx_in == 5'd28));
        if (idx_in < 5'd26) begin
            chr = 8'h41 + {3'b000, idx_in};
        end else if (idx_in == 5'd26) begin
            chr = 8'h08;
        end
    end

    // Stability filter; a character is staged for one cycle when the count first reaches STABLE.
    always_comb begin
        last_idx_d  = last_idx_q;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        pend_char_d = pend_char_q;
        if (valid_i) begin
            if (!qual) begin
                last_idx_d = IDX_NONE;
                cnt_d      = 4'd0;
            end else if (idx_in == last_idx_q) begin
                if (cnt_q != STABLE) begin
                    cnt_d       = cnt_q + 4'd1;
                    pend_d      = (cnt_q == STABLE - 4'd1);
                    pend_char_d = chr;
                end
            end else begin
                last_idx_d  = idx_in;
                cnt_d       = 4'd1;
                pend_d      = (STABLE == 4'd1);
                pend_char_d = chr;
            end
        end
    end

    // Hold register, overflow flag and UART frame sequencer.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        ovf_d       = ovf_q;
        take        = 1'b0;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    take    = 1'b1;
                    shift_d = hold_data_q;
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            hold_full_d = 1'b0;
        end
        // A write into a slot being emptied this same cycle is accepted.
        if (pend_q) begin
            if (!hold_full_q || take) begin
                hold_full_d = 1'b1;
                hold_data_d = pend_char_q;
            end else begin
                ovf_d = 1'b1;
            end
        end
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers; tx and busy are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            last_idx_q  <= IDX_NONE;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            pend_char_q <= 8'h00;
            hold_full_q <= 1'b0;
            hold_data_q <= 8'h00;
            ovf_q       <= 1'b0;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_idx_q  <= last_idx_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_char_q <= pend_char_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            ovf_q       <= ovf_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign tx     = tx_q;
    assign busy_o = busy_q;
    assign ovf_o  = ovf_q;

endmodule

// File: doc/asl_result_tx.md
ASL_RESULT_TX -- requirements
Module: asl_result_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (>=2).
REQ-002 SHALL have parameter STABLE_COUNT, default 4, meaning consecutive identical qualified results required before emitting a character (1..15).
REQ-003 SHALL have parameter CONF_THRESH, default 8'd64, meaning minimum winning score accepted as a detection.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  8  winning class score from the argmax pipeline, unsigned.
REQ-007 SHALL have port idx_in  input  5  winning class index.
REQ-008 SHALL have port valid_i  input  1  single-cycle strobe qualifying data_in/idx_in.
REQ-009 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy_o  output  1  high while a frame is on tx.
REQ-011 SHALL have port ovf_o  output  1  sticky flag, character dropped because the hold register was full.

Function
REQ-012 SHALL act on valid_i only; inputs are ignored in cycles where valid_i is low.
REQ-013 SHALL map the index: 0..25 -> 0x41+idx ('A'..'Z'); 26 -> 0x08 (del); 27 -> "nothing" (no character); 28 -> 0x20 (space); 29..31 -> invalid.
REQ-014 SHALL treat a result as "nothing" when data_in < CONF_THRESH (data_in == CONF_THRESH qualifies), when idx is 27, or when idx is 29..31.
REQ-015 SHALL, on a qualified result equal to last_idx, increment a stability counter that saturates at STABLE_COUNT.
REQ-016 SHALL, on a qualified result different from last_idx, load last_idx with the new index and set the counter to 1.
REQ-017 SHALL, on a "nothing" result, clear the counter and set last_idx to the 27 marker.
REQ-018 SHALL queue exactly one character when the counter becomes STABLE_COUNT; a held sign never repeats until a different or "nothing" result intervenes; with STABLE_COUNT=1, every change of qualified index queues one character.
REQ-019 SHALL write a queued character into a one-entry hold register in the cycle after the valid_i edge.
REQ-020 SHALL, when the hold register is full and its contents are not being consumed in the same cycle, drop the new character and set ovf_o; ovf_o clears only on reset.
REQ-021 SHALL implement a TX FSM with states IDLE, START, DATA, STOP.
REQ-022 SHALL, in IDLE with the hold register full, load the shift register, free the hold register, and enter START on the next edge; hold-register free and a new write in the same cycle SHALL succeed without ovf_o.
REQ-023 SHALL hold START (tx=0), each of the 8 DATA bits (LSB first), and STOP (tx=1) for CLKS_PER_BIT cycles each, then return to IDLE; a frame is 10*CLKS_PER_BIT cycles.
REQ-024 SHALL drive busy_o high exactly during START, DATA, and STOP.
REQ-025 SHALL allow back-to-back frames: from STOP expiry, a pending hold character enters START via IDLE with one idle cycle (tx=1).
REQ-026 SHALL register tx, so that it is glitch-free.

Reset
REQ-027 SHALL, on resetn low at any time, including mid-frame, immediately force tx=1, busy_o=0, ovf_o=0, FSM=IDLE, hold register empty, counter=0, last_idx=27, with all bit and baud counters at 0.
REQ-028 SHALL NOT resume an aborted frame after reset release.

Verification (CLKS_PER_BIT=4, STABLE_COUNT=3, CONF_THRESH=64)
REQ-029 SHALL cover: three valid_i strobes with idx=2, data=100 -> one frame carrying 0x43 ('C'), tx bits 0,1,1,0,0,0,0,1,0,1 each 4 cycles, busy_o high 40 cycles.
REQ-030 SHALL cover: five strobes with idx=2, data=100 -> exactly one 'C' frame; then idx=27, then three strobes with idx=2 -> a second 'C'.
REQ-031 SHALL cover: idx=5 with data 100,63,100,100 -> no frame (the 63 resets the count); one further strobe with idx=5 -> 0x46 ('F').
REQ-032 SHALL cover: strobe streams queuing 'A', then 'B', then 'C' while the 'A' frame is active -> 'A' and 'B' transmitted, 'C' dropped, ovf_o=1.
REQ-033 SHALL cover: idx=28 ×3 then idx=26 ×3 -> frames 0x20 then 0x08; idx=30 ×3 -> no frame.
REQ-034 SHALL cover: resetn asserted during the DATA state -> tx=1 and busy_o=0 in the same cycle, no further frame after release.
